// File: rtl/div_sequencer_pkg.sv
// Shared CPU constants for the multi-cycle divider: the FSM encoding, the iteration count
// and the quotient that a divide-by-zero returns.
package div_sequencer_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_CALC = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int          DIV_ITER     = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // Two's-complement magnitude when en is set.  0x80000000 maps to itself, which is the
    // correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the remainder/quotient pair left by one bit,
// then subtract the divisor when the trial difference does not borrow.
module div_step
    import div_sequencer_pkg::*;
(
    input  logic [31:0] i_rem,
    input  logic [31:0] i_quo,
    input  logic [31:0] i_dvs,
    output logic [31:0] o_rem,
    output logic [31:0] o_quo
);

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fits;

    // The remainder is always below the divisor, so 33 bits hold the shifted value and the
    // sign bit of the difference is a reliable borrow flag.
    assign w_shift = {i_rem, i_quo[31]};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign w_fits  = ~w_diff[32];

    assign o_rem = w_fits ? w_diff[31:0] : w_shift[31:0];
    assign o_quo = {i_quo[30:0], w_fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: latches operands, runs 32 restoring
// iterations, fixes up signs and presents quotient (LO) and remainder (HI) with a done pulse.
module div_sequencer
    import div_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_ex,
    input  logic        signed_ex,
    input  logic [31:0] rdata1_ex,
    input  logic [31:0] rdata2_ex,
    input  logic        flush,
    output logic        stall_ex,
    output logic        busy,
    output logic        done,
    output logic [31:0] lo_out,
    output logic [31:0] hi_out,
    output logic [2:0]  o_dbg_state
);

    logic [2:0]  r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_signed;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_q_neg;
    logic        r_r_neg;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    logic        w_accept;
    logic [31:0] w_step_rem;
    logic [31:0] w_step_quo;

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // flush beats a same-cycle request so a cancelled instruction never stalls the pipe.
    assign w_accept = (r_state == ST_IDLE) && start_ex && !flush;

    assign stall_ex = w_accept || (r_state == ST_PREP) || (r_state == ST_CALC)
                      || (r_state == ST_FIX);
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign lo_out      = r_lo;
    assign hi_out      = r_hi;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 5'd0;
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_signed   <= 1'b0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_dvs      <= 32'd0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_lo       <= 32'd0;
            r_hi       <= 32'd0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_ex) begin
                        r_dividend <= rdata1_ex;
                        r_divisor  <= rdata2_ex;
                        r_signed   <= signed_ex;
                        r_state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    r_q_neg <= r_signed & (r_dividend[31] ^ r_divisor[31]);
                    r_r_neg <= r_signed & r_dividend[31];
                    r_quo   <= abs32(r_dividend, r_signed);
                    r_dvs   <= abs32(r_divisor, r_signed);
                    r_rem   <= 32'd0;
                    r_cnt   <= 5'd0;
                    // Divide-by-zero bypasses the iterations; the raw dividend is the remainder.
                    if (r_divisor == 32'd0) begin
                        r_lo    <= DIV_ZERO_QUO;
                        r_hi    <= r_dividend;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(DIV_ITER - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_lo    <= r_q_neg ? (~r_quo + 32'd1) : r_quo;
                    r_hi    <= r_r_neg ? (~r_rem + 32'd1) : r_rem;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port start_ex, input, 1 bit: EX-stage DIV/DIVU issue request.
REQ-004 The block SHALL have port signed_ex, input, 1 bit: 1 = DIV (signed), 0 = DIVU (unsigned).
REQ-005 The block SHALL have port rdata1_ex, input, 32 bits: dividend, GPR read port 1.
REQ-006 The block SHALL have port rdata2_ex, input, 32 bits: divisor, GPR read port 2.
REQ-007 The block SHALL have port flush, input, 1 bit: exception/cancel; aborts any operation.
REQ-008 The block SHALL have port stall_ex, output, 1 bit: holds EX stage while the divide is pending.
REQ-009 The block SHALL have port busy, output, 1 bit: sequencer not in IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse for the HI/LO write.
REQ-011 The block SHALL have port lo_out, output, 32 bits: quotient.
REQ-012 The block SHALL have port hi_out, output, 32 bits: remainder.

Function
REQ-013 The block SHALL implement states IDLE, PREP, CALC, FIX and DONE.
REQ-014 In IDLE with start_ex=1 and flush=0, the block SHALL latch rdata1_ex, rdata2_ex and signed_ex (cycle 0) and go to PREP.
REQ-015 PREP (cycle 1) SHALL form absolute values of the operands when signed, record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign), and go to CALC, or to DONE if the divisor is 0.
REQ-016 CALC SHALL run exactly 32 restoring shift-subtract iterations (cycles 2..33) under a 5-bit iteration counter, then go to FIX.
REQ-017 FIX (cycle 34) SHALL apply the recorded signs to the quotient and remainder and go to DONE.
REQ-018 DONE (cycle 35) SHALL assert done=1 for exactly one cycle with lo_out/hi_out valid, then go to IDLE.
REQ-019 Latency from start to done SHALL be 35 cycles for a nonzero divisor and 2 cycles for a zero divisor.
REQ-020 A zero divisor SHALL produce lo_out=32'hFFFFFFFF and hi_out=dividend, unmodified by sign handling.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0 (two's-complement wrap, no trap).
REQ-022 stall_ex SHALL be combinationally 1 in IDLE when start_ex=1 and flush=0, and 1 in PREP, CALC and FIX.
REQ-023 stall_ex SHALL be 0 in DONE and 0 in IDLE otherwise.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start_ex SHALL be ignored while busy=1.
REQ-026 flush=1 in any state SHALL force IDLE on the next edge with no done pulse, and lo_out/hi_out SHALL keep their previous values.
REQ-027 flush and start_ex asserted together in IDLE SHALL leave the request unaccepted (flush wins) and stall_ex=0.
REQ-028 lo_out/hi_out SHALL update only on entry to DONE and SHALL hold until the next DONE.

Reset
REQ-029 rst=1 on a rising edge SHALL force IDLE, clear the counter, operand and result registers, and drive lo_out=0, hi_out=0, done=0, busy=0, stall_ex=0.
REQ-030 Reset mid-operation SHALL abort without a done pulse, and reset SHALL take priority over flush and start_ex.

Structure
REQ-031 The state encoding (3-bit), DIV_ITER=32 and the divide-by-zero quotient constant 32'hFFFFFFFF SHALL reside in the shared CPU package.
REQ-032 One combinational sub-module, div_step, SHALL perform a single restoring iteration (shift remainder/quotient pair, trial subtract, select); the FSM, counter and sign logic SHALL stay in div_sequencer.

Verification
REQ-033 The bench SHALL check: DIVU 100/7 started at cycle 0 -> done at cycle 35, lo_out=14, hi_out=2, stall_ex high on cycles 0..34.
REQ-034 The bench SHALL check: DIV -7/2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF; and DIV 7/-2 -> lo_out=0xFFFFFFFD, hi_out=1.
REQ-035 The bench SHALL check: DIVU 5/0 -> done at cycle 2, lo_out=0xFFFFFFFF, hi_out=5.
REQ-036 The bench SHALL check: DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0 at cycle 35.
REQ-037 The bench SHALL check: flush at cycle 10 -> IDLE at cycle 11, no done, outputs unchanged; a start at cycle 11 is accepted normally.
REQ-038 The bench SHALL check: rst at cycle 20 -> all outputs 0 next cycle; start_ex pulsed at cycle 15 while busy -> ignored.
